lfsr_gen: RTL

Parametrised Fibonacci LFSR pattern generator. It is the next generation of the fixed 8-bit LFSR, now with configurable width and taps, a synchronous seed load, lock-up recovery, period-wrap detection and a framed serial dump of the state. It sits beside BIST/scrambler logic and feeds pseudo-random words both in parallel (state) and serially (out/valid).

---
 rtl/lfsr_gen_if.sv | 26 ++
 rtl/lfsr_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lfsr_gen_if.sv
// Signal bundle between an lfsr_gen pattern generator and its consumer.
// The master drives seed/strobes; the slave (generator) returns state and the serial dump.
interface lfsr_gen_if #(
  parameter int LFSR_WD = 8
);
  logic [LFSR_WD-1:0] seed;
  logic               load;
  logic               enable;
  logic               out_enable;
  logic [LFSR_WD-1:0] state;
  logic               out;
  logic               valid;
  logic               busy;
  logic               wrap;
  logic               lockup;

  modport master (
    output seed, load, enable, out_enable,
    input  state, out, valid, busy, wrap, lockup
  );

  modport slave (
    input  seed, load, enable, out_enable,
    output state, out, valid, busy, wrap, lockup
  );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, lock-up repair, wrap detection
// and an LSB-first framed serial dump of a snapshot of the state.
module lfsr_gen #(
  parameter int                 LFSR_WD    = 8,
  parameter logic [LFSR_WD-1:0] TAPS       = LFSR_WD'(8'hB8),
  parameter logic [LFSR_WD-1:0] RESET_SEED = LFSR_WD'(8'h01)
) (
  input logic        clk,
  input logic        rst,
  lfsr_gen_if.slave  bus
);

  localparam int                IDX_WD   = $clog2(LFSR_WD);
  localparam logic [IDX_WD-1:0] LAST_IDX = IDX_WD'(LFSR_WD - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DUMP = 1'b1
  } fsm_t;

  fsm_t               fsm, fsm_nxt;
  logic [LFSR_WD-1:0] lfsr, lfsr_nxt;
  logic [LFSR_WD-1:0] ref_seed, ref_seed_nxt;
  logic [LFSR_WD-1:0] snap, snap_nxt;
  logic [IDX_WD-1:0]  idx, idx_nxt;
  logic               oe_prev;
  logic               out_bit, out_bit_nxt;
  logic               dump_valid, dump_valid_nxt;
  logic               dump_busy, dump_busy_nxt;
  logic               wrap_pulse, wrap_pulse_nxt;
  logic               lock_pulse, lock_pulse_nxt;
  logic               oe_rise;
  logic [LFSR_WD-1:0] stepped;
  logic [IDX_WD-1:0]  idx_inc;

  function automatic logic feedback(input logic [LFSR_WD-1:0] s);
    return ^(s & TAPS);
  endfunction

  function automatic logic [LFSR_WD-1:0] lfsr_step(input logic [LFSR_WD-1:0] s);
    return {s[LFSR_WD-2:0], feedback(s)};
  endfunction

  assign oe_rise = bus.out_enable & ~oe_prev;
  assign stepped = lfsr_step(lfsr);
  assign idx_inc = idx + IDX_WD'(1'b1);

  // Next-state logic: register update by priority, then dump sequencing.
  always_comb begin
    fsm_nxt        = fsm;
    lfsr_nxt       = lfsr;
    ref_seed_nxt   = ref_seed;
    snap_nxt       = snap;
    idx_nxt        = idx;
    out_bit_nxt    = 1'b0;
    dump_valid_nxt = 1'b0;
    dump_busy_nxt  = 1'b0;
    wrap_pulse_nxt = 1'b0;
    lock_pulse_nxt = 1'b0;

    // A zero seed would lock the register, so it is replaced by RESET_SEED.
    if (bus.load) begin
      if (bus.seed == '0) begin
        lfsr_nxt       = RESET_SEED;
        ref_seed_nxt   = RESET_SEED;
        lock_pulse_nxt = 1'b1;
      end else begin
        lfsr_nxt     = bus.seed;
        ref_seed_nxt = bus.seed;
      end
    end else if (lfsr == '0) begin
      lfsr_nxt       = RESET_SEED;
      lock_pulse_nxt = 1'b1;
    end else if ((fsm == IDLE) && !oe_rise && bus.enable) begin
      lfsr_nxt       = stepped;
      wrap_pulse_nxt = (stepped == ref_seed);
    end else begin
      lfsr_nxt = lfsr;
    end

    case (fsm)
      IDLE: begin
        if (!bus.load && (lfsr != '0) && oe_rise) begin
          fsm_nxt        = DUMP;
          snap_nxt       = lfsr;
          idx_nxt        = '0;
          out_bit_nxt    = lfsr[0];
          dump_valid_nxt = 1'b1;
          dump_busy_nxt  = 1'b1;
        end else begin
          fsm_nxt = IDLE;
        end
      end
      DUMP: begin
        if (idx == LAST_IDX) begin
          fsm_nxt = IDLE;
          idx_nxt = '0;
        end else begin
          idx_nxt        = idx_inc;
          out_bit_nxt    = snap[idx_inc];
          dump_valid_nxt = 1'b1;
          dump_busy_nxt  = 1'b1;
        end
      end
      default: begin
        fsm_nxt = IDLE;
        idx_nxt = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm        <= IDLE;
      lfsr       <= RESET_SEED;
      ref_seed   <= RESET_SEED;
      snap       <= '0;
      idx        <= '0;
      oe_prev    <= 1'b0;
      out_bit    <= 1'b0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      wrap_pulse <= 1'b0;
      lock_pulse <= 1'b0;
    end else begin
      fsm        <= fsm_nxt;
      lfsr       <= lfsr_nxt;
      ref_seed   <= ref_seed_nxt;
      snap       <= snap_nxt;
      idx        <= idx_nxt;
      oe_prev    <= bus.out_enable;
      out_bit    <= out_bit_nxt;
      dump_valid <= dump_valid_nxt;
      dump_busy  <= dump_busy_nxt;
      wrap_pulse <= wrap_pulse_nxt;
      lock_pulse <= lock_pulse_nxt;
    end
  end

  assign bus.state  = lfsr;
  assign bus.out    = out_bit;
  assign bus.valid  = dump_valid;
  assign bus.busy   = dump_busy;
  assign bus.wrap   = wrap_pulse;
  assign bus.lockup = lock_pulse;

endmodule
